// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler: scoreboard of pending destinations, RAW/WAW issue stall,
// and a round-robin arbiter that merges the ALU and load-unit writebacks onto one write port.
module rf_wb_scheduler #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_issue_valid,
  input  logic [AW-1:0]   i_issue_rs1,
  input  logic            i_issue_use_rs1,
  input  logic [AW-1:0]   i_issue_rs2,
  input  logic            i_issue_use_rs2,
  input  logic [AW-1:0]   i_issue_rd,
  output logic            o_issue_stall,
  input  logic            i_flush,
  input  logic            i_alu_valid,
  input  logic [AW-1:0]   i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  output logic            o_alu_ready,
  input  logic            i_mem_valid,
  input  logic [AW-1:0]   i_mem_rd,
  input  logic [XLEN-1:0] i_mem_data,
  output logic            o_mem_ready,
  output logic            o_rf_we,
  output logic [AW-1:0]   o_rf_rd_addr,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic [NREG-1:0] o_busy_vec,
  output logic            o_err_spurious
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_d;
  logic            r_last_mem;
  logic            r_rf_we;
  logic [AW-1:0]   r_rf_rd_addr;
  logic [XLEN-1:0] r_rf_wdata;
  logic            r_err_spurious;

  logic            w_alu_grant;
  logic            w_mem_grant;
  logic            w_grant;
  logic            w_issue_accept;
  logic [AW-1:0]   w_wb_rd;
  logic [XLEN-1:0] w_wb_data;

  // Stall looks only at the registered scoreboard; a clear lands one cycle before issue sees it.
  assign o_issue_stall = i_issue_valid &
                         ((i_issue_use_rs1 & r_busy[i_issue_rs1]) |
                          (i_issue_use_rs2 & r_busy[i_issue_rs2]) |
                          ((i_issue_rd != '0) & r_busy[i_issue_rd]));

  assign w_issue_accept = i_issue_valid & ~o_issue_stall & ~i_flush;

  // On contention the requester not granted last wins; r_last_mem moves only on a grant.
  assign w_alu_grant = i_alu_valid & (~i_mem_valid | r_last_mem);
  assign w_mem_grant = i_mem_valid & (~i_alu_valid | ~r_last_mem);
  assign w_grant     = w_alu_grant | w_mem_grant;
  assign w_wb_rd     = w_alu_grant ? i_alu_rd : i_mem_rd;
  assign w_wb_data   = w_alu_grant ? i_alu_data : i_mem_data;

  always_comb begin
    w_busy_d = r_busy;
    if (w_issue_accept && (i_issue_rd != '0)) begin
      w_busy_d[i_issue_rd] = 1'b1;
    end
    if (r_rf_we) begin
      w_busy_d[r_rf_rd_addr] = 1'b0;
    end
    if (i_flush) begin
      w_busy_d = '0;
    end
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy         <= '0;
      r_last_mem     <= 1'b1;
      r_rf_we        <= 1'b0;
      r_rf_rd_addr   <= '0;
      r_rf_wdata     <= '0;
      r_err_spurious <= 1'b0;
    end else begin
      r_busy  <= w_busy_d;
      r_rf_we <= w_grant & (w_wb_rd != '0);
      if (w_grant) begin
        r_last_mem <= w_mem_grant;
      end
      if (w_grant && (w_wb_rd != '0)) begin
        r_rf_rd_addr <= w_wb_rd;
        r_rf_wdata   <= w_wb_data;
      end
      // A write landing on a register nobody is waiting for is flagged sticky.
      if (r_rf_we && !r_busy[r_rf_rd_addr]) begin
        r_err_spurious <= 1'b1;
      end
    end
  end

  assign o_alu_ready    = w_alu_grant;
  assign o_mem_ready    = w_mem_grant;
  assign o_rf_we        = r_rf_we;
  assign o_rf_rd_addr   = r_rf_rd_addr;
  assign o_rf_wdata     = r_rf_wdata;
  assign o_busy_vec     = r_busy;
  assign o_err_spurious = r_err_spurious;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: directed scenarios followed by a randomized run checked against
// a cycle-level behavioural model of the scoreboard, arbiter and write port.
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_issue_valid, i_issue_use_rs1, i_issue_use_rs2, i_flush;
  logic [4:0]  i_issue_rs1, i_issue_rs2, i_issue_rd;
  logic        o_issue_stall;
  logic        i_alu_valid, i_mem_valid;
  logic [4:0]  i_alu_rd, i_mem_rd;
  logic [31:0] i_alu_data, i_mem_data;
  logic        o_alu_ready, o_mem_ready;
  logic        o_rf_we;
  logic [4:0]  o_rf_rd_addr;
  logic [31:0] o_rf_wdata;
  logic [31:0] o_busy_vec;
  logic        o_err_spurious;

  int n_tests = 0;
  int n_fail  = 0;

  rf_wb_scheduler #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .i_issue_valid(i_issue_valid), .i_issue_rs1(i_issue_rs1), .i_issue_use_rs1(i_issue_use_rs1),
    .i_issue_rs2(i_issue_rs2), .i_issue_use_rs2(i_issue_use_rs2), .i_issue_rd(i_issue_rd),
    .o_issue_stall(o_issue_stall), .i_flush(i_flush),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .o_alu_ready(o_alu_ready),
    .i_mem_valid(i_mem_valid), .i_mem_rd(i_mem_rd), .i_mem_data(i_mem_data),
    .o_mem_ready(o_mem_ready),
    .o_rf_we(o_rf_we), .o_rf_rd_addr(o_rf_rd_addr), .o_rf_wdata(o_rf_wdata),
    .o_busy_vec(o_busy_vec), .o_err_spurious(o_err_spurious)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_issue_valid = 0; i_issue_use_rs1 = 0; i_issue_use_rs2 = 0; i_flush = 0;
    i_issue_rs1 = 0; i_issue_rs2 = 0; i_issue_rd = 0;
    i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
    i_mem_valid = 0; i_mem_rd = 0; i_mem_data = 0;
  endtask

  // Leaves the bench 2 time units after a rising edge; inputs are driven and sampled there.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    i_issue_valid = 1; i_issue_rd = rd;
    tick();
    i_issue_valid = 0; i_issue_rd = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (o_busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy got %h want 0", o_busy_vec); end
    n_tests++; if (o_rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", o_rf_we); end
    n_tests++; if (o_rf_rd_addr !== 5'd0 || o_rf_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rf got addr %0d data %h want 0/0", o_rf_rd_addr, o_rf_wdata); end
    n_tests++; if (o_err_spurious !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", o_err_spurious); end
  endtask

  task automatic test_issue_and_writeback();
    do_reset();
    i_issue_valid = 1; i_issue_rd = 5;
    #1;
    n_tests++; if (o_issue_stall !== 1'b0) begin n_fail++; $display("FAIL issue5_stall got %b want 0", o_issue_stall); end
    tick();
    i_issue_valid = 0; i_issue_rd = 0;
    #1;
    n_tests++; if (o_busy_vec !== 32'h20) begin n_fail++; $display("FAIL issue5_busy got %h want 00000020", o_busy_vec); end
    n_tests++; if (o_rf_we !== 1'b0) begin n_fail++; $display("FAIL issue5_we got %b want 0", o_rf_we); end
    i_issue_valid = 1; i_issue_use_rs1 = 1; i_issue_rs1 = 5; i_issue_rd = 6;
    i_alu_valid = 1; i_alu_rd = 5; i_alu_data = 32'hDEADBEEF;
    #1;
    n_tests++; if (o_issue_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall got %b want 1", o_issue_stall); end
    n_tests++; if (o_alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu5_ready got %b want 1", o_alu_ready); end
    tick();
    i_alu_valid = 0;
    #1;
    n_tests++; if (o_rf_we !== 1'b1 || o_rf_rd_addr !== 5'd5 || o_rf_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wb5 got we %b addr %0d data %h want 1/5/deadbeef", o_rf_we, o_rf_rd_addr, o_rf_wdata); end
    n_tests++; if (o_issue_stall !== 1'b1) begin n_fail++; $display("FAIL stall_hold got %b want 1", o_issue_stall); end
    tick();
    #1;
    n_tests++; if (o_issue_stall !== 1'b0) begin n_fail++; $display("FAIL stall_drop got %b want 0", o_issue_stall); end
    n_tests++; if (o_rf_we !== 1'b0) begin n_fail++; $display("FAIL wb5_we_low got %b want 0", o_rf_we); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_rd(3);
    issue_rd(4);
    i_alu_valid = 1; i_alu_rd = 3; i_alu_data = 32'hA;
    i_mem_valid = 1; i_mem_rd = 4; i_mem_data = 32'hB;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++; if (o_alu_ready !== (k % 2 == 0) || o_mem_ready !== (k % 2 == 1)) begin
        n_fail++; $display("FAIL rr_grant%0d got alu %b mem %b want alu %b", k, o_alu_ready, o_mem_ready, k % 2 == 0); end
      if (k > 0) begin
        n_tests++; if (o_rf_we !== 1'b1 || o_rf_rd_addr !== ((k % 2 == 1) ? 5'd3 : 5'd4)) begin
          n_fail++; $display("FAIL rr_addr%0d got we %b addr %0d", k, o_rf_we, o_rf_rd_addr); end
      end
      tick();
    end
    idle_inputs();
    #1;
    n_tests++; if (o_rf_we !== 1'b1 || o_rf_rd_addr !== 5'd4 || o_rf_wdata !== 32'hB) begin
      n_fail++; $display("FAIL rr_last got we %b addr %0d data %h want 1/4/b", o_rf_we, o_rf_rd_addr, o_rf_wdata); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    issue_rd(9);
    i_mem_valid = 1; i_mem_rd = 0; i_mem_data = 32'h1234;
    #1;
    n_tests++; if (o_mem_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready got %b want 1", o_mem_ready); end
    tick();
    i_mem_valid = 0;
    #1;
    n_tests++; if (o_rf_we !== 1'b0 || o_rf_rd_addr !== 5'd0 || o_rf_wdata !== 32'h0) begin
      n_fail++; $display("FAIL rd0_we got we %b addr %0d data %h want 0/0/0", o_rf_we, o_rf_rd_addr, o_rf_wdata); end
    n_tests++; if (o_busy_vec !== 32'h200) begin n_fail++; $display("FAIL rd0_busy got %h want 00000200", o_busy_vec); end
  endtask

  task automatic test_spurious();
    do_reset();
    i_alu_valid = 1; i_alu_rd = 7; i_alu_data = 32'h77;
    tick();
    i_alu_valid = 0;
    #1;
    n_tests++; if (o_rf_we !== 1'b1 || o_rf_rd_addr !== 5'd7) begin
      n_fail++; $display("FAIL spur_write got we %b addr %0d want 1/7", o_rf_we, o_rf_rd_addr); end
    tick();
    n_tests++; if (o_err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_err got %b want 1", o_err_spurious); end
    repeat (3) tick();
    n_tests++; if (o_err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_sticky got %b want 1", o_err_spurious); end
  endtask

  task automatic test_reset_and_flush();
    do_reset();
    for (int r = 4; r < 8; r++) issue_rd(5'(r));
    i_alu_valid = 1; i_alu_rd = 4; i_alu_data = 32'h44;
    tick();
    i_alu_valid = 0;
    #1;
    n_tests++; if (o_busy_vec !== 32'hF0 || o_rf_we !== 1'b1) begin
      n_fail++; $display("FAIL pre_rst got busy %h we %b want 000000f0/1", o_busy_vec, o_rf_we); end
    rst = 1;
    #1;
    n_tests++; if (o_busy_vec !== 32'h0 || o_rf_we !== 1'b0) begin
      n_fail++; $display("FAIL async_rst got busy %h we %b want 0/0", o_busy_vec, o_rf_we); end
    tick();
    rst = 0;
    for (int r = 4; r < 8; r++) issue_rd(5'(r));
    i_flush = 1; i_issue_valid = 1; i_issue_rd = 8;
    tick();
    idle_inputs();
    n_tests++; if (o_busy_vec !== 32'h0) begin n_fail++; $display("FAIL flush got busy %h want 0", o_busy_vec); end
  endtask

  // Behavioural model state for the randomized run.
  logic [31:0] m_busy;
  logic        m_last_mem, m_we, m_err;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        alu_pend, mem_pend;

  function automatic logic [4:0] pick_rd(input logic [31:0] busy);
    if (busy != 0 && $urandom_range(3) != 0) begin
      for (int t = 0; t < 64; t++) begin
        logic [4:0] c = 5'($urandom_range(31));
        if (busy[c]) return c;
      end
    end
    return 5'($urandom_range(31));
  endfunction

  task automatic test_random();
    logic exp_stall, exp_alu, exp_mem, acc;
    logic [4:0] g_rd;
    logic [31:0] g_data, nb;
    do_reset();
    m_busy = 0; m_last_mem = 1; m_we = 0; m_err = 0; m_addr = 0; m_data = 0;
    alu_pend = 0; mem_pend = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_tests++; if (o_rf_we !== m_we || o_rf_rd_addr !== m_addr || o_rf_wdata !== m_data) begin
        n_fail++; $display("FAIL rnd_rf c%0d got %b/%0d/%h want %b/%0d/%h", cyc, o_rf_we, o_rf_rd_addr,
                           o_rf_wdata, m_we, m_addr, m_data); end
      n_tests++; if (o_busy_vec !== m_busy || o_err_spurious !== m_err) begin
        n_fail++; $display("FAIL rnd_state c%0d got busy %h err %b want %h %b", cyc, o_busy_vec,
                           o_err_spurious, m_busy, m_err); end
      i_issue_valid = $urandom_range(1); i_issue_use_rs1 = $urandom_range(1);
      i_issue_use_rs2 = $urandom_range(1); i_issue_rs1 = pick_rd(m_busy);
      i_issue_rs2 = 5'($urandom_range(31)); i_issue_rd = 5'($urandom_range(31));
      i_flush = ($urandom_range(29) == 0);
      if (!alu_pend && $urandom_range(1) == 1) begin
        alu_pend = 1; i_alu_rd = pick_rd(m_busy); i_alu_data = $urandom;
      end
      if (!mem_pend && $urandom_range(2) == 0) begin
        mem_pend = 1; i_mem_rd = pick_rd(m_busy); i_mem_data = $urandom;
      end
      i_alu_valid = alu_pend; i_mem_valid = mem_pend;
      #1;
      exp_stall = i_issue_valid && ((i_issue_use_rs1 && m_busy[i_issue_rs1]) ||
                  (i_issue_use_rs2 && m_busy[i_issue_rs2]) || (i_issue_rd != 0 && m_busy[i_issue_rd]));
      if (alu_pend && mem_pend) begin exp_alu = m_last_mem; exp_mem = !m_last_mem; end
      else begin exp_alu = alu_pend; exp_mem = mem_pend; end
      n_tests++; if (o_issue_stall !== exp_stall || o_alu_ready !== exp_alu || o_mem_ready !== exp_mem) begin
        n_fail++; $display("FAIL rnd_comb c%0d got stall %b alu %b mem %b want %b %b %b", cyc,
                           o_issue_stall, o_alu_ready, o_mem_ready, exp_stall, exp_alu, exp_mem); end
      // Advance the model across the coming edge.
      acc = i_issue_valid && !exp_stall && !i_flush;
      nb = m_busy;
      if (acc && i_issue_rd != 0) nb[i_issue_rd] = 1;
      if (m_we) begin
        if (!m_busy[m_addr]) m_err = 1;
        nb[m_addr] = 0;
      end
      if (i_flush) nb = 0;
      nb[0] = 0;
      m_busy = nb;
      g_rd = exp_alu ? i_alu_rd : i_mem_rd;
      g_data = exp_alu ? i_alu_data : i_mem_data;
      m_we = (exp_alu || exp_mem) && g_rd != 0;
      if (m_we) begin m_addr = g_rd; m_data = g_data; end
      if (exp_alu) begin m_last_mem = 0; alu_pend = 0; end
      if (exp_mem) begin m_last_mem = 1; mem_pend = 0; end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    #3;
    test_reset();
    test_issue_and_writeback();
    test_back_to_back();
    test_rd_zero();
    test_spurious();
    test_reset_and_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
